// File: rtl/cic_cfg_pkg.sv
// Shared types and constants for the CIC rate sequencer.
// Provides the sequencer state encoding and ratio helpers.
package cic_cfg_pkg;

  typedef enum logic [1:0] {
    FLUSH,
    APPLY,
    SETTLE,
    RUN
  } state_e;

  localparam int CFG_MIN_RATIO     = 2;
  localparam int CFG_MAX_RATIO     = 4096;
  localparam int CFG_DEFAULT_RATIO = 64;

  // ceil_log2(0) and ceil_log2(1) both yield 0
  function automatic logic [4:0] ceil_log2(input logic [15:0] r);
    logic [15:0] m;
    logic [4:0]  n;
    n = 5'd0;
    if (r == 16'd0) return n;
    m = r - 16'd1;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) n = 5'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/cic_shift_calc.sv
// Bit-growth shift for a CIC of order STAGES at a given ratio,
// saturated so the kept output window stays inside the accumulator.
module cic_shift_calc
  import cic_cfg_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 5
) (
  input  logic [15:0] ratio_i,
  output logic [5:0]  shift_o
);

  localparam int CAP = WIDTH - 8;

  logic [4:0] lg;
  logic [9:0] prod;

  assign lg   = ceil_log2(ratio_i);
  assign prod = 10'(lg) * 10'(STAGES);

  assign shift_o = (prod > 10'(CAP)) ? 6'(CAP) : prod[5:0];

endmodule

// File: rtl/cic_rate_sequencer.sv
// Ratio request handshake, CIC flush/apply/settle sequencing,
// settle watchdog and output muting for the receive CIC.
module cic_rate_sequencer
  import cic_cfg_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int STAGES        = 5,
  parameter int MIN_RATIO     = CFG_MIN_RATIO,
  parameter int MAX_RATIO     = CFG_MAX_RATIO,
  parameter int DEFAULT_RATIO = CFG_DEFAULT_RATIO,
  parameter int FLUSH_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_ratio,
  output logic        cfg_ready,
  output logic        cfg_err,
  output logic        cic_rst,
  output logic [15:0] cic_ratio,
  output logic [5:0]  cic_shift,
  input  logic        cic_dclk,
  output logic        out_valid,
  output logic        timeout,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] ratio_q, ratio_d;
  logic [5:0]  shift_q, shift_d;
  logic [7:0]  flush_q, flush_d;
  logic [7:0]  edge_q, edge_d;
  logic [17:0] wd_q, wd_d;
  logic        to_q, to_d;
  logic        err_q, err_d;
  logic        dclk_q, dclk_p_q;

  logic [15:0] calc_in;
  logic [5:0]  shift_w;
  logic [17:0] wd_lim;
  logic        rise;
  logic        in_range;

  assign calc_in = rst ? 16'(DEFAULT_RATIO) : pend_q;

  cic_shift_calc #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_shift (
    .ratio_i (calc_in),
    .shift_o (shift_w)
  );

  assign wd_lim = 18'(({2'b00, ratio_q} << 1) * 18'(STAGES + 1)
                  + 18'd16);
  assign rise   = dclk_q & ~dclk_p_q;
  assign in_range = (cfg_ratio >= 16'(MIN_RATIO))
                  && (cfg_ratio <= 16'(MAX_RATIO));

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ratio_d = ratio_q;
    shift_d = shift_q;
    flush_d = 8'd0;
    edge_d  = edge_q;
    wd_d    = wd_q;
    to_d    = to_q;
    err_d   = 1'b0;
    unique case (state_q)
      FLUSH: begin
        if (flush_q == 8'(FLUSH_CYCLES - 1)) state_d = APPLY;
        else flush_d = flush_q + 8'd1;
      end
      APPLY: begin
        ratio_d = pend_q;
        shift_d = shift_w;
        edge_d  = 8'd0;
        wd_d    = 18'd0;
        state_d = SETTLE;
      end
      SETTLE: begin
        wd_d = wd_q + 18'd1;
        if (rise) begin
          if (edge_q == 8'(STAGES)) state_d = RUN;
          else edge_d = edge_q + 8'd1;
        end
        // settle completion wins over an expiring watchdog
        if (state_d != RUN && wd_q == wd_lim - 18'd1) begin
          to_d    = 1'b1;
          state_d = FLUSH;
        end
      end
      RUN: begin
        if (cfg_valid) begin
          if (in_range) begin
            pend_d  = cfg_ratio;
            to_d    = 1'b0;
            state_d = FLUSH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FLUSH;
      pend_q   <= 16'(DEFAULT_RATIO);
      ratio_q  <= 16'(DEFAULT_RATIO);
      shift_q  <= shift_w;
      flush_q  <= 8'd0;
      edge_q   <= 8'd0;
      wd_q     <= 18'd0;
      to_q     <= 1'b0;
      err_q    <= 1'b0;
      dclk_q   <= 1'b0;
      dclk_p_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      ratio_q  <= ratio_d;
      shift_q  <= shift_d;
      flush_q  <= flush_d;
      edge_q   <= edge_d;
      wd_q     <= wd_d;
      to_q     <= to_d;
      err_q    <= err_d;
      dclk_q   <= cic_dclk;
      dclk_p_q <= dclk_q;
    end
  end

  assign cic_rst   = (state_q == FLUSH);
  assign cic_ratio = ratio_q;
  assign cic_shift = shift_q;
  assign cfg_ready = (state_q == RUN);
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q != RUN);
  assign timeout   = to_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_cic_rate_sequencer.sv
// Directed bench for the CIC rate sequencer: boot, reconfig,
// range errors, shift saturation, watchdog and mid-op reset.
module tb_cic_rate_sequencer;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic [15:0] cfg_ratio;
  logic        cfg_ready;
  logic        cfg_err;
  logic        cic_rst;
  logic [15:0] cic_ratio;
  logic [5:0]  cic_shift;
  logic        cic_dclk;
  logic        out_valid;
  logic        timeout;
  logic        busy;

  int vecs = 0;
  int miss = 0;
  int dclk_div = 64;
  int phase = 0;

  cic_rate_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cic_rst   (cic_rst),
    .cic_ratio (cic_ratio),
    .cic_shift (cic_shift),
    .cic_dclk  (cic_dclk),
    .out_valid (out_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output-rate strobe model: one-clk pulse every dclk_div clks
  initial begin
    cic_dclk = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (dclk_div == 0) begin
        cic_dclk = 1'b0;
      end else begin
        phase++;
        if (phase >= dclk_div) begin
          phase = 0;
          cic_dclk = 1'b1;
        end else begin
          cic_dclk = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: sim time %0t exceeded budget", $time);
    $fatal(1, "bench hung");
  end

  task automatic run_seq(output int fl, output int ed, output bit ok);
    int n;
    fl = 0;
    ed = 0;
    ok = 1'b0;
    n  = 0;
    while (cic_rst === 1'b1 && n < 64) begin
      fl++;
      n++;
      @(negedge clk);
    end
    n = 0;
    while (n < 60000) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      ed += int'(cic_dclk);
    end
  endtask

  task automatic apply_ratio(input logic [15:0] r, output bit rdy,
                             output bit post_ov, output int fl,
                             output int ed, output bit ok);
    dclk_div  = int'(r);
    rdy       = cfg_ready;
    cfg_valid = 1'b1;
    cfg_ratio = r;
    @(negedge clk);
    cfg_valid = 1'b0;
    post_ov   = out_valid;
    run_seq(fl, ed, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ratio = 16'd0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({cic_rst, busy, out_valid, cfg_ready, cfg_err, timeout}
        !== 6'b110000) begin
      miss++;
      $display("FAIL reset_flags: got %b want 110000",
               {cic_rst, busy, out_valid, cfg_ready, cfg_err, timeout});
    end
    vecs++;
    if (cic_ratio !== 16'd64) begin
      miss++;
      $display("FAIL reset_ratio: got %0d want 64", cic_ratio);
    end
    vecs++;
    if (cic_shift !== 6'd30) begin
      miss++;
      $display("FAIL reset_shift: got %0d want 30", cic_shift);
    end
  endtask

  task automatic test_boot(input string tag);
    int fl, ed;
    bit ok;
    dclk_div = 64;
    rst = 1'b0;
    run_seq(fl, ed, ok);
    vecs++;
    if (fl !== 8) begin
      miss++;
      $display("FAIL %s_flush: got %0d clks want 8", tag, fl);
    end
    vecs++;
    if (ok !== 1'b1 || ed !== 6) begin
      miss++;
      $display("FAIL %s_settle: got ok=%0d edges=%0d want 1/6",
               tag, ok, ed);
    end
    vecs++;
    if ({cic_ratio, cic_shift, busy, cfg_ready}
        !== {16'd64, 6'd30, 1'b0, 1'b1}) begin
      miss++;
      $display("FAIL %s_run: got ratio=%0d shift=%0d busy=%b rdy=%b want 64/30/0/1",
               tag, cic_ratio, cic_shift, busy, cfg_ready);
    end
  endtask

  task automatic test_reconfig();
    int fl, ed;
    bit ok, rdy, pov;
    apply_ratio(16'd100, rdy, pov, fl, ed, ok);
    vecs++;
    if (rdy !== 1'b1 || pov !== 1'b0) begin
      miss++;
      $display("FAIL reconfig_hs: got rdy=%b ov_after=%b want 1/0", rdy, pov);
    end
    vecs++;
    if (fl !== 8 || ed !== 6 || ok !== 1'b1) begin
      miss++;
      $display("FAIL reconfig_seq: got fl=%0d ed=%0d ok=%0d want 8/6/1",
               fl, ed, ok);
    end
    vecs++;
    if (cic_ratio !== 16'd100 || cic_shift !== 6'd35) begin
      miss++;
      $display("FAIL reconfig_val: got %0d/%0d want 100/35",
               cic_ratio, cic_shift);
    end
  endtask

  task automatic test_range();
    logic [15:0] bad [2];
    bad[0] = 16'd1;
    bad[1] = 16'd5000;
    for (int i = 0; i < 2; i++) begin
      cfg_valid = 1'b1;
      cfg_ratio = bad[i];
      @(negedge clk);
      cfg_valid = 1'b0;
      vecs++;
      if ({cfg_err, out_valid, cfg_ready} !== 3'b111
          || cic_ratio !== 16'd100) begin
        miss++;
        $display("FAIL range_err_%0d: got err=%b ov=%b rdy=%b ratio=%0d want 1/1/1/100",
                 bad[i], cfg_err, out_valid, cfg_ready, cic_ratio);
      end
      @(negedge clk);
      vecs++;
      if (cfg_err !== 1'b0 || out_valid !== 1'b1) begin
        miss++;
        $display("FAIL range_pulse_%0d: got err=%b ov=%b want 0/1",
                 bad[i], cfg_err, out_valid);
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] r [2];
    logic [5:0]  s [2];
    int fl, ed;
    bit ok, rdy, pov;
    r[0] = 16'd4096; s[0] = 6'd56;
    r[1] = 16'd2;    s[1] = 6'd5;
    for (int i = 0; i < 2; i++) begin
      apply_ratio(r[i], rdy, pov, fl, ed, ok);
      vecs++;
      if (ok !== 1'b1 || cic_ratio !== r[i] || cic_shift !== s[i]) begin
        miss++;
        $display("FAIL sat_%0d: got ok=%0d ratio=%0d shift=%0d want 1/%0d/%0d",
                 r[i], ok, cic_ratio, cic_shift, r[i], s[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    int n, lo, fl, ed;
    bit ok;
    dclk_div  = 0;
    cfg_valid = 1'b1;
    cfg_ratio = 16'd16;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = 0;
    while (cic_rst === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    lo = 0;
    while (cic_rst === 1'b0 && lo < 1000) begin
      lo++;
      @(negedge clk);
    end
    vecs++;
    if (lo !== 209) begin
      miss++;
      $display("FAIL wd_span: got %0d low clks want 209 (1 apply + 208 settle)", lo);
    end
    vecs++;
    if (timeout !== 1'b1 || cic_ratio !== 16'd16 || cic_shift !== 6'd20) begin
      miss++;
      $display("FAIL wd_flag: got to=%b ratio=%0d shift=%0d want 1/16/20",
               timeout, cic_ratio, cic_shift);
    end
    dclk_div = 16;
    run_seq(fl, ed, ok);
    vecs++;
    if (fl !== 8 || ed !== 6 || ok !== 1'b1 || timeout !== 1'b1) begin
      miss++;
      $display("FAIL wd_retry: got fl=%0d ed=%0d ok=%0d to=%b want 8/6/1/1",
               fl, ed, ok, timeout);
    end
    dclk_div  = 32;
    cfg_valid = 1'b1;
    cfg_ratio = 16'd32;
    @(negedge clk);
    cfg_valid = 1'b0;
    vecs++;
    if (timeout !== 1'b0 || cic_rst !== 1'b1) begin
      miss++;
      $display("FAIL wd_clear: got to=%b cic_rst=%b want 0/1", timeout, cic_rst);
    end
    run_seq(fl, ed, ok);
    vecs++;
    if (ok !== 1'b1 || cic_shift !== 6'd25) begin
      miss++;
      $display("FAIL wd_after: got ok=%0d shift=%0d want 1/25", ok, cic_shift);
    end
  endtask

  task automatic test_midop_reset(input bit in_settle);
    int n;
    dclk_div  = 100;
    cfg_valid = 1'b1;
    cfg_ratio = 16'd100;
    @(negedge clk);
    cfg_valid = 1'b0;
    if (in_settle) begin
      n = 0;
      while (cic_rst === 1'b1 && n < 64) begin
        n++;
        @(negedge clk);
      end
      repeat (20) @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cic_rst, busy, out_valid, cfg_ready, cfg_err, timeout} !== 6'b110000
        || cic_ratio !== 16'd64 || cic_shift !== 6'd30) begin
      miss++;
      $display("FAIL midrst_%0d: got flags=%b ratio=%0d shift=%0d want 110000/64/30",
               in_settle,
               {cic_rst, busy, out_valid, cfg_ready, cfg_err, timeout},
               cic_ratio, cic_shift);
    end
    test_boot(in_settle ? "reboot_settle" : "reboot_flush");
  endtask

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ratio = 16'd0;
    test_reset();
    test_boot("boot");
    test_reconfig();
    test_range();
    test_saturation();
    test_watchdog();
    test_midop_reset(1'b0);
    apply_settled_100();
    test_midop_reset(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  task automatic apply_settled_100();
    int fl, ed;
    bit ok, rdy, pov;
    apply_ratio(16'd100, rdy, pov, fl, ed, ok);
    vecs++;
    if (ok !== 1'b1 || cic_ratio !== 16'd100) begin
      miss++;
      $display("FAIL pre_settle_rst: got ok=%0d ratio=%0d want 1/100",
               ok, cic_ratio);
    end
  endtask

endmodule
